pwm_duty_decoder: RTL and testbench

Receive-side counterpart of the square-wave/PWM generator. Samples a free-running pulse train on `sysclk`, measures its period and high time in clock cycles, and converts the ratio to a duty-cycle code on the same 0..64 scale the generator uses, where 64 means 100 %. Sits at the board input, feeding status and loop-back checking logic that compares the recovered duty cycle against the programmed one.

---
 rtl/pwm_duty_decoder.sv | 178 +++++++++++++++++
 tb/tb_pwm_duty_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// PWM duty-cycle decoder: measures period and high time of Pulse_In, divides to a 0..64 duty code.
// Optional PWM_DEC_GLITCH_FILTER_EN adds a 3-sample agreement filter after the synchronizer.
module pwm_duty_decoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             Enable,
   input  logic             Pulse_In,
   output logic [CNT_W-1:0] Period,
   output logic [CNT_W-1:0] High_Time,
   output logic [6:0]       Duty_Cycle,
   output logic             Valid,
   output logic             Stuck,
   output logic             Overrun,
   output logic             Busy
);

   localparam int unsigned QW  = 7;
   localparam int unsigned ITW = 3;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [QW-1:0]    DUTY_FULL = QW'(64);
   localparam logic [ITW-1:0]   LAST_IT   = ITW'(QW-1);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           state, state_nxt;
   logic             sync1, sync2, prev, synced, rise;
   logic [CNT_W-1:0] per_cnt, hi_cnt, per_new, hi_new;
   logic [CNT_W-1:0] rem;
   logic [CNT_W:0]   trial;
   logic [QW-1:0]    num_lo;
   logic [QW-2:0]    quo;
   logic [ITW-1:0]   it_cnt;
   logic             ge, start, ovr, tout, restart;

   // Two-flop synchronizer plus the delayed copy used for edge detection
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= Pulse_In;
         sync2 <= sync1;
         prev  <= synced;
      end
   end

`ifdef PWM_DEC_GLITCH_FILTER_EN
   logic hist1, hist2;

   // Filtered level follows sync2 only once three consecutive samples agree
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         hist1 <= 1'b0;
         hist2 <= 1'b0;
      end else begin
         hist1 <= sync2;
         hist2 <= hist1;
      end
   end

   assign synced = (sync2 == hist1 && hist1 == hist2) ? sync2 : prev;
`else
   assign synced = sync2;
`endif

   assign rise    = synced & ~prev;
   assign per_new = per_cnt + CNT_W'(1);
   assign hi_new  = hi_cnt + CNT_W'(synced);
   assign trial   = {rem, num_lo[QW-1]};
   assign ge      = (trial >= {1'b0, Period});

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state and per-cycle control strobes
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      ovr       = 1'b0;
      tout      = 1'b0;
      restart   = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = MEASURE;
               restart   = 1'b1;
            end
         end
         MEASURE: begin
            if (per_cnt == CNT_MAX) begin
               tout      = 1'b1;
               state_nxt = IDLE;
            end else if (rise) begin
               restart = 1'b1;
               if (Busy) ovr   = 1'b1;
               else      start = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!Enable) begin
         state_nxt = IDLE;
         start     = 1'b0;
         ovr       = 1'b0;
         tout      = 1'b0;
         restart   = 1'b0;
      end
   end

   // Period and high-time counters; a rising edge reloads them to count its own cycle
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end else if (state_nxt == MEASURE && !restart) begin
         per_cnt <= per_new;
         hi_cnt  <= hi_new;
      end else begin
         per_cnt <= '0;
         hi_cnt  <= '0;
      end
   end

   // Result latch and restoring divider; only 7 quotient bits are needed since High_Time <= Period
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         Period     <= '0;
         High_Time  <= '0;
         Duty_Cycle <= '0;
         Valid      <= 1'b0;
         Stuck      <= 1'b0;
         Overrun    <= 1'b0;
         Busy       <= 1'b0;
         rem        <= '0;
         num_lo     <= '0;
         quo        <= '0;
         it_cnt     <= '0;
      end else begin
         Valid   <= 1'b0;
         Overrun <= ovr;
         if (!Enable) begin
            Busy <= 1'b0;
         end else if (tout) begin
            Period     <= CNT_MAX;
            High_Time  <= synced ? CNT_MAX : '0;
            Duty_Cycle <= synced ? DUTY_FULL : '0;
            Stuck      <= 1'b1;
            Valid      <= 1'b1;
            Busy       <= 1'b0;
         end else if (start) begin
            Period    <= per_new;
            High_Time <= hi_new;
            rem       <= hi_new >> 1;
            num_lo    <= {hi_new[0], (QW-1)'(0)};
            quo       <= '0;
            it_cnt    <= '0;
            Busy      <= 1'b1;
         end else if (Busy) begin
            rem    <= ge ? CNT_W'(trial - {1'b0, Period}) : trial[CNT_W-1:0];
            num_lo <= {num_lo[QW-2:0], 1'b0};
            quo    <= {quo[QW-3:0], ge};
            it_cnt <= it_cnt + ITW'(1);
            if (it_cnt == LAST_IT) begin
               Busy       <= 1'b0;
               Valid      <= 1'b1;
               Duty_Cycle <= {quo, ge};
               Stuck      <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: table of waveforms, random waveforms, timeout, enable abort and reset.
module tb_pwm_duty_decoder;

   localparam int unsigned CNT_W = 16;
   localparam int TOUT = 65536;

   logic             sysclk = 1'b0;
   logic             rst_n  = 1'b0;
   logic             Enable = 1'b0;
   logic             Pulse_In = 1'b0;
   logic [CNT_W-1:0] Period, High_Time;
   logic [6:0]       Duty_Cycle;
   logic             Valid, Stuck, Overrun, Busy;

   always #5 sysclk = ~sysclk;

   pwm_duty_decoder #(.CNT_W(CNT_W)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .Enable(Enable), .Pulse_In(Pulse_In),
      .Period(Period), .High_Time(High_Time), .Duty_Cycle(Duty_Cycle),
      .Valid(Valid), .Stuck(Stuck), .Overrun(Overrun), .Busy(Busy)
   );

   typedef struct { int cyc; int duty; bit stuck; } vrec_t;
   typedef struct { int hi; int lo; int reps; int e_per; int e_hi; int e_duty; } vec_t;

   vrec_t vq[$];
   int    oq[$];
   vec_t  tbl[7];

   int checks = 0;
   int errors = 0;
   int k = 0;
   bit l1, l2, l3, armed;
   int last_det = 0, hcount = 0, s_last = -1000;
   int mdl_per = 0, mdl_hi = 0, mdl_duty = 0;
   bit mdl_stuck = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, k, act, exp);
      end
   endtask

   // Reference: rising edge at input cycle n is seen at n+2; result 7 cycles later unless a divide is pending
   task automatic model_edge(input bit lvl, input bit en);
      bit r;
      r = l2 && !l3;
      if (!en) begin
         armed = 1'b0;
         while (vq.size() > 0 && vq[vq.size()-1].cyc >= k) vq.pop_back();
         s_last = -1000;
      end else if (armed && k == last_det + TOUT) begin
         mdl_per = 65535;
         mdl_hi  = l2 ? 65535 : 0;
         vq.push_back('{k, (l2 ? 64 : 0), 1'b1});
         armed = 1'b0;
      end else if (r) begin
         if (armed) begin
            if (k > s_last && k <= s_last + 7) oq.push_back(k);
            else begin
               mdl_per = k - last_det;
               mdl_hi  = hcount;
               vq.push_back('{k + 7, (hcount * 64) / (k - last_det), 1'b0});
               s_last = k;
            end
         end
         armed = 1'b1;
         last_det = k;
         hcount = 0;
      end
      if (armed) hcount += int'(l2);
      l3 = l2; l2 = l1; l1 = lvl;
   endtask

   task automatic check_cycle();
      bit ev, eo, eb;
      ev = vq.size() > 0 && vq[0].cyc == k;
      if (Valid || ev) begin
         chk("valid", int'(Valid), int'(ev));
         if (ev) begin
            mdl_duty  = vq[0].duty;
            mdl_stuck = vq[0].stuck;
            if (Valid) begin
               chk("period", int'(Period), mdl_per);
               chk("high_time", int'(High_Time), mdl_hi);
               chk("duty", int'(Duty_Cycle), mdl_duty);
               chk("stuck", int'(Stuck), int'(mdl_stuck));
            end
            void'(vq.pop_front());
         end
      end
      eo = oq.size() > 0 && oq[0] == k;
      if (Overrun || eo) chk("overrun", int'(Overrun), int'(eo));
      if (eo) void'(oq.pop_front());
      eb = (k >= s_last) && (k < s_last + 7);
      if (Busy || eb) chk("busy", int'(Busy), int'(eb));
   endtask

   task automatic step(input bit lvl, input bit en);
      Pulse_In = lvl;
      Enable   = en;
      k++;
      model_edge(lvl, en);
      @(posedge sysclk);
      #1;
      check_cycle();
   endtask

   task automatic play(input int hi, input int lo, input int reps, input bit en);
      for (int r = 0; r < reps; r++) begin
         repeat (hi) step(1'b1, en);
         repeat (lo) step(1'b0, en);
      end
   endtask

   task automatic chk_outs(input string tag, input int p, input int h, input int d, input int s);
      chk({tag, "_period"}, int'(Period), p);
      chk({tag, "_high"}, int'(High_Time), h);
      chk({tag, "_duty"}, int'(Duty_Cycle), d);
      chk({tag, "_stuck"}, int'(Stuck), s);
   endtask

   initial begin
      tbl[0] = '{32, 32, 5,  64, 32, 32};
      tbl[1] = '{1,  99, 4, 100,  1,  0};
      tbl[2] = '{99,  1, 4, 100, 99, 63};
      tbl[3] = '{16, 48, 4,  64, 16, 16};
      tbl[4] = '{2,   2, 6,   4,  2, 32};
      tbl[5] = '{4,   3, 6,   7,  4, 36};
      tbl[6] = '{5,   3, 6,   8,  5, 40};

      repeat (2) @(posedge sysclk);
      #1;
      chk_outs("reset", 0, 0, 0, 0);
      chk("reset_valid", int'(Valid), 0);
      chk("reset_overrun", int'(Overrun), 0);
      chk("reset_busy", int'(Busy), 0);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         play(tbl[i].hi, tbl[i].lo, tbl[i].reps, 1'b1);
         repeat (12) step(1'b0, 1'b1);
         chk("tbl_period", int'(Period), tbl[i].e_per);
         chk("tbl_high", int'(High_Time), tbl[i].e_hi);
         chk("tbl_duty", int'(Duty_Cycle), tbl[i].e_duty);
      end

      for (int i = 0; i < 60; i++) begin
         int p, h;
         p = (i % 8 == 0) ? int'($urandom_range(100, 300)) : int'($urandom_range(2, 40));
         h = int'($urandom_range(1, p - 1));
         play(h, p - h, int'($urandom_range(1, 3)), 1'b1);
      end

      // Line stuck high: one timeout result, then recovery on a 64/16 wave
      repeat (TOUT + 4) step(1'b1, 1'b1);
      chk_outs("stuck", 65535, 65535, 64, 1);
      repeat (48) step(1'b0, 1'b1);
      play(16, 48, 3, 1'b1);
      repeat (12) step(1'b0, 1'b1);
      chk_outs("recover", 64, 16, 16, 0);

      // Enable dropped three cycles into a divide
      play(32, 32, 3, 1'b1);
      play(20, 60, 1, 1'b1);
      repeat (5) step(1'b1, 1'b1);
      repeat (27) step(1'b1, 1'b0);
      repeat (32) step(1'b0, 1'b0);
      chk_outs("abort", 80, 20, 32, 0);
      chk("abort_busy", int'(Busy), 0);
      play(32, 32, 3, 1'b1);

      // Asynchronous reset while the divider is running
      repeat (5) step(1'b1, 1'b1);
      chk("pre_reset_busy", int'(Busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_outs("midreset", 0, 0, 0, 0);
      chk("midreset_busy", int'(Busy), 0);
      Pulse_In = 1'b0;
      repeat (3) begin
         @(posedge sysclk);
         k++;
      end
      vq.delete();
      oq.delete();
      armed = 1'b0; s_last = -1000; l1 = 1'b0; l2 = 1'b0; l3 = 1'b0;
      mdl_per = 0; mdl_hi = 0; mdl_duty = 0; mdl_stuck = 1'b0;
      #2 rst_n = 1'b1;
      play(32, 32, 3, 1'b1);
      repeat (20) step(1'b0, 1'b1);
      chk_outs("final", 64, 32, 32, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
